// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan decoder.
//   - segment bit indices within a sampled byte {a,b,c,d,e,f,g,dp}
//   - 7-bit segment patterns (a..g) for hex digits 0-F, blank and minus
//   - 5-bit digit codes for blank, minus and undecodable patterns
//   - is_onehot(): digit-enable validity check
package seg_pkg;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Patterns are {a,b,c,d,e,f,g}
  localparam logic [6:0] PAT_0     = 7'b1111110;
  localparam logic [6:0] PAT_1     = 7'b0110000;
  localparam logic [6:0] PAT_2     = 7'b1101101;
  localparam logic [6:0] PAT_3     = 7'b1111001;
  localparam logic [6:0] PAT_4     = 7'b0110011;
  localparam logic [6:0] PAT_5     = 7'b1011011;
  localparam logic [6:0] PAT_6     = 7'b1011111;
  localparam logic [6:0] PAT_7     = 7'b1110000;
  localparam logic [6:0] PAT_8     = 7'b1111111;
  localparam logic [6:0] PAT_9     = 7'b1111011;
  localparam logic [6:0] PAT_A     = 7'b1110111;
  localparam logic [6:0] PAT_B     = 7'b0011111;
  localparam logic [6:0] PAT_C     = 7'b1001110;
  localparam logic [6:0] PAT_D     = 7'b0111101;
  localparam logic [6:0] PAT_E     = 7'b1001111;
  localparam logic [6:0] PAT_F     = 7'b1000111;
  localparam logic [6:0] PAT_BLANK = 7'b0000000;
  localparam logic [6:0] PAT_MINUS = 7'b0000001;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_MINUS = 5'd17;
  localparam logic [4:0] CODE_ERR   = 5'd31;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational segment-byte decoder.
// Ports:
//   pattern [7:0] in  : sampled segments {a,b,c,d,e,f,g,dp}, active-high
//   code    [4:0] out : 0-15 for hex digits, 16 blank, 17 minus, 31 otherwise
//   dp            out : decimal-point bit, passed through
//   err           out : pattern did not match any known character
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [4:0] code,
  output logic       dp,
  output logic       err
);

  logic [6:0] segs;

  assign segs = pattern[SEG_A:SEG_G];
  assign dp   = pattern[SEG_DP];

  always_comb begin
    code = CODE_ERR;
    err  = 1'b0;
    unique case (segs)
      PAT_0:     code = 5'd0;
      PAT_1:     code = 5'd1;
      PAT_2:     code = 5'd2;
      PAT_3:     code = 5'd3;
      PAT_4:     code = 5'd4;
      PAT_5:     code = 5'd5;
      PAT_6:     code = 5'd6;
      PAT_7:     code = 5'd7;
      PAT_8:     code = 5'd8;
      PAT_9:     code = 5'd9;
      PAT_A:     code = 5'd10;
      PAT_B:     code = 5'd11;
      PAT_C:     code = 5'd12;
      PAT_D:     code = 5'd13;
      PAT_E:     code = 5'd14;
      PAT_F:     code = 5'd15;
      PAT_BLANK: code = CODE_BLANK;
      PAT_MINUS: code = CODE_MINUS;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers an 8-digit frame from a multiplexed
// seven-segment display scan.
// Parameters:
//   STABLE_CYC  : identical consecutive samples needed to accept a digit
//   TIMEOUT_CYC : cycles without an acceptance before scan_lost sets
// Ports:
//   clk, rst (sync, active-high)
//   seg_en [7:0]  : digit enables, nominally one-hot
//   seg0   [7:0]  : segments for digits 7..4; seg1 [7:0]: digits 3..0
//   frame_digits [39:0] : digit i code in [5i+4:5i]
//   frame_dp [7:0], frame_valid (1-cycle pulse), frame_err
//   scan_lost : only when SEG_SCAN_TIMEOUT_EN is defined
// Build option: SEG_SCAN_TIMEOUT_EN adds the lost-scan timeout.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_en,
  input  logic [7:0]  seg0,
  input  logic [7:0]  seg1,
  output logic [39:0] frame_digits,
  output logic [7:0]  frame_dp,
  output logic        frame_valid,
  output logic        frame_err
`ifdef SEG_SCAN_TIMEOUT_EN
  ,
  output logic        scan_lost
`endif
);

  localparam int unsigned SW = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYC);

  logic [7:0]    en_q, s0_q, s1_q;
  logic [7:0]    prev_en, prev_pat;
  logic [SW-1:0] stab_cnt, stab_next;
  logic [2:0]    idx;
  logic [7:0]    pat_sel;
  logic          sample_ok, same, accept, latch;
  logic [4:0]    dec_code;
  logic          dec_dp, dec_err;
  logic [39:0]   work_digits;
  logic [7:0]    work_dp, seen, seen_nx;
  logic          work_err, err_nx;

  seg_pattern_decode u_decode (
    .pattern (pat_sel),
    .code    (dec_code),
    .dp      (dec_dp),
    .err     (dec_err)
  );

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (en_q[i]) idx = 3'(i);
    end
  end

  assign sample_ok = is_onehot(en_q);
  assign pat_sel   = idx[2] ? s0_q : s1_q;
  assign same      = (en_q == prev_en) && (pat_sel == prev_pat);
  assign latch     = (seen == 8'hFF);

  // Counter saturates at STABLE_MAX; acceptance fires only on the transition
  // into STABLE_MAX so a held sample is accepted exactly once.
  always_comb begin
    stab_next = '0;
    if (sample_ok) begin
      if (same && stab_cnt != '0)
        stab_next = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + SW'(1);
      else
        stab_next = SW'(1);
    end
  end

  assign accept = sample_ok && (stab_next == STABLE_MAX) &&
                  !(same && stab_cnt == STABLE_MAX);

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_FULL = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = !accept && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      scan_lost <= 1'b0;
    end else if (accept) begin
      tmo_cnt   <= '0;
      scan_lost <= 1'b0;
    end else begin
      if (tmo_cnt != TMO_FULL) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) scan_lost <= 1'b1;
    end
  end
`else
  // TIMEOUT_CYC only matters when the timeout is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  // Latch clears the mask first so an acceptance in the same cycle
  // lands in the next frame.
  always_comb begin
    seen_nx = latch ? '0 : seen;
    err_nx  = latch ? 1'b0 : work_err;
    if (accept) begin
      seen_nx[idx] = 1'b1;
      err_nx       = err_nx | dec_err;
    end
`ifdef SEG_SCAN_TIMEOUT_EN
    if (tmo_hit) seen_nx = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= '0;
      s0_q         <= '0;
      s1_q         <= '0;
      prev_en      <= '0;
      prev_pat     <= '0;
      stab_cnt     <= '0;
      work_digits  <= '0;
      work_dp      <= '0;
      work_err     <= 1'b0;
      seen         <= '0;
      frame_digits <= '0;
      frame_dp     <= '0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      en_q        <= seg_en;
      s0_q        <= seg0;
      s1_q        <= seg1;
      prev_en     <= en_q;
      prev_pat    <= pat_sel;
      stab_cnt    <= stab_next;
      frame_valid <= 1'b0;
      if (latch) begin
        frame_digits <= work_digits;
        frame_dp     <= work_dp;
        frame_err    <= work_err;
        frame_valid  <= 1'b1;
      end
      if (accept) begin
        work_digits[5*int'(idx) +: 5] <= dec_code;
        work_dp[idx]                  <= dec_dp;
      end
      seen     <= seen_nx;
      work_err <= err_nx;
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL provide parameter STABLE_CYC, default 4: the number of consecutive identical samples required to accept a digit.
REQ-002 The block SHALL provide parameter TIMEOUT_CYC, default 1048576: the number of cycles without an accepted digit before the scan is declared lost.
REQ-003 Port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port seg_en, input, 8 bits: digit enables, active-high, nominally one-hot.
REQ-006 Port seg0, input, 8 bits: segment pattern for digits 7..4, bit order {a,b,c,d,e,f,g,dp}, active-high.
REQ-007 Port seg1, input, 8 bits: segment pattern for digits 3..0, same bit order.
REQ-008 Port frame_digits, output, 40 bits: eight 5-bit digit codes; digit i occupies bits [5i+4:5i].
REQ-009 Port frame_dp, output, 8 bits: decimal-point state per digit.
REQ-010 Port frame_valid, output, 1 bit: one-cycle pulse when a new frame is latched.
REQ-011 Port frame_err, output, 1 bit: latched frame contains at least one undecodable pattern.
REQ-012 Port scan_lost, output, 1 bit: present only with SEG_SCAN_TIMEOUT_EN.

Function
REQ-013 The block SHALL register seg_en, seg0 and seg1 once per cycle before use.
REQ-014 Sample selection: seg_en[i], i>=4, SHALL select seg0; i<4 SHALL select seg1.
REQ-015 Sample validity: a zero or multi-hot seg_en SHALL be an invalid sample, and an invalid sample SHALL clear the stability counter.
REQ-016 Stability counting: the stability counter SHALL increment while {seg_en, selected pattern} equals the previous sample, and SHALL reload to 1 on any change.
REQ-017 Acceptance: when the counter reaches STABLE_CYC, the digit SHALL be accepted exactly once; further cycles of the same sample SHALL be no-ops until the sample changes.
REQ-018 On acceptance, the decoded 5-bit code and the dp bit SHALL be written to working slot i, and bit i of the seen-mask SHALL be set.
REQ-019 Decode table: patterns for 0-9 and A-F SHALL map to codes 0-15, blank (all segments off) to 16, and minus (g only) to 17; any other pattern SHALL map to 31 and set the working error flag.
REQ-020 Frame latch: in the cycle after the seen-mask becomes 8'hFF, working slots SHALL copy to frame_digits and frame_dp, the working error flag SHALL copy to frame_err, frame_valid SHALL pulse, and the mask and working error flag SHALL clear.
REQ-021 Simultaneous events: an acceptance in the frame-latch cycle SHALL count toward the next frame.
REQ-022 Repeated digits: re-accepting an already-seen digit before the frame completes SHALL overwrite its slot and SHALL NOT complete the frame.
REQ-023 Output hold: frame outputs SHALL hold between frame latches.
REQ-024 Latency: frame_valid SHALL assert 1 (input register) + STABLE_CYC + 1 cycles after the final digit's sample first appears at the inputs.

Reset
REQ-025 While rst is high at a clk edge, frame_digits SHALL be 0, frame_dp 0, frame_valid 0, frame_err 0 and scan_lost 0.
REQ-026 Reset SHALL also clear the seen-mask, working slots, the stability counter and the timeout counter.
REQ-027 A reset mid-frame SHALL discard partial frame content.

Configuration
REQ-028 With macro SEG_SCAN_TIMEOUT_EN defined, a counter SHALL count cycles since the last acceptance.
REQ-029 With SEG_SCAN_TIMEOUT_EN defined, at TIMEOUT_CYC scan_lost SHALL set and the seen-mask SHALL clear; the next acceptance SHALL clear scan_lost.
REQ-030 Without SEG_SCAN_TIMEOUT_EN, the scan_lost port and the timeout counter SHALL be absent, and the block SHALL wait indefinitely.

Structure
REQ-031 Package seg_pkg SHALL hold the segment-pattern constants for 0-F, blank and minus, the code constants (CODE_BLANK=16, CODE_MINUS=17, CODE_ERR=31), and the segment bit-index constants.
REQ-032 Sub-module seg_pattern_decode SHALL be the combinational 8-bit pattern to {code, dp, err} decoder, instantiated once.

Verification
REQ-033 Full scan: scan digits 0-7 with patterns for 1..8, 8 cycles per digit -> one frame_valid; frame_digits codes are 1..8; frame_err=0.
REQ-034 Glitch rejection: hold a digit 3 cycles, then change it (STABLE_CYC=4) -> no acceptance; that slot stays unseen.
REQ-035 Invalid inputs: insert seg_en=8'h00 and 8'h11 between digits -> ignored; the frame still completes correctly.
REQ-036 Bad pattern: send pattern 8'b1010_1010 on digit 5 -> frame_digits[29:25]=31, frame_err=1; a subsequent clean frame gives frame_err=0.
REQ-037 Reset mid-frame: assert rst after 5 digits, then scan 8 -> exactly one frame_valid, after the 8 post-reset digits.
REQ-038 Timeout (macro on, TIMEOUT_CYC=64): stop the scan for 64 cycles -> scan_lost=1; resume the scan -> scan_lost=0 on the first acceptance.
